// File: rtl/progloader_pkg.sv
// progloader_pkg: shared types and constants for the boot-time program loader.
//   state_t          - loader FSM states (CHK only present with PROGLOADER_CHKSUM_EN)
//   PL_DEFAULT_DEPTH - default instruction memory capacity in words
//   PL_HI_FIRST      - stream byte order for instruction words (high byte first)
//   pl_pack()        - assembles a 16-bit word from two stream bytes in stream order
// Optional feature macro: PROGLOADER_CHKSUM_EN.
package progloader_pkg;

    localparam int unsigned PL_DEFAULT_DEPTH = 1024;
    localparam bit          PL_HI_FIRST      = 1'b1;

    typedef enum logic [2:0] {
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DAT_HI,
        ST_DAT_LO,
`ifdef PROGLOADER_CHKSUM_EN
        ST_CHK,
`endif
        ST_FLUSH,
        ST_RUN,
        ST_ERR
    } state_t;

    // first/second are the bytes in the order they arrive on the stream
    function automatic logic [15:0] pl_pack(input logic [7:0] first, input logic [7:0] second);
        return PL_HI_FIRST ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/progloader.sv
// progloader: receives a byte stream (count hi/lo, then N big-endian words,
// then an optional checksum byte), writes the words sequentially into
// instruction memory and holds the CPU in reset until the load completes.
// Optional feature macro: PROGLOADER_CHKSUM_EN (XOR checksum byte after data).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rx_data/valid     - incoming stream byte and its valid
//   rx_ready          - loader can accept a byte this cycle
//   mem_waddr/data/we - instruction memory write port (one-cycle strobe)
//   cpu_rst           - CPU reset, high until the load completes
//   done / error      - load complete (CPU running) / load failed (sticky)
//   words_loaded      - words written so far
module progloader
    import progloader_pkg::*;
#(
    parameter int unsigned DEPTH = PL_DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] mem_waddr,
    output logic [15:0] mem_data,
    output logic        mem_we,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

`ifdef PROGLOADER_CHKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CHK;
`else
    localparam state_t ST_AFTER_DATA = ST_FLUSH;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt_hi;
    logic [15:0] r_rem;
    logic [7:0]  r_hi;
    logic [15:0] r_wdata;
    logic        r_we;
    logic [15:0] r_words;
    logic        w_ready;
    logic        w_accept;
    logic [15:0] w_count;
    logic        w_count_gt;
`ifdef PROGLOADER_CHKSUM_EN
    logic [7:0]  r_chk;
`endif

    assign w_count    = pl_pack(r_cnt_hi, rx_data);
    assign w_count_gt = ({16'd0, w_count} > DEPTH);
    assign w_accept   = w_ready & rx_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CNT_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        cpu_rst = 1'b1;
        done    = 1'b0;
        error   = 1'b0;
        case (r_state)
            ST_CNT_HI: begin
                w_ready = 1'b1;
                if (rx_valid) w_next = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                w_ready = 1'b1;
                if (rx_valid) begin
                    if (w_count_gt)          w_next = ST_ERR;
                    else if (w_count == '0)  w_next = ST_AFTER_DATA;
                    else                     w_next = ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                w_ready = 1'b1;
                if (rx_valid) w_next = ST_DAT_LO;
            end
            ST_DAT_LO: begin
                w_ready = 1'b1;
                if (rx_valid) w_next = (r_rem == 16'd1) ? ST_AFTER_DATA : ST_DAT_HI;
            end
`ifdef PROGLOADER_CHKSUM_EN
            ST_CHK: begin
                w_ready = 1'b1;
                if (rx_valid) w_next = (rx_data == r_chk) ? ST_FLUSH : ST_ERR;
            end
`endif
            ST_FLUSH: w_next = ST_RUN;
            ST_RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            ST_ERR: error = 1'b1;
            default: w_next = ST_CNT_HI;
        endcase
        rx_ready = w_ready;
    end

    // words_loaded advances at the end of each write pulse, so mem_waddr can
    // be taken straight from it while the strobe is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_hi <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_words  <= '0;
`ifdef PROGLOADER_CHKSUM_EN
            r_chk    <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            if (r_we) r_words <= r_words + 16'd1;
            if (w_accept) begin
                case (r_state)
                    ST_CNT_HI: r_cnt_hi <= rx_data;
                    ST_CNT_LO: r_rem <= w_count;
                    ST_DAT_HI: begin
                        r_hi <= rx_data;
`ifdef PROGLOADER_CHKSUM_EN
                        r_chk <= r_chk ^ rx_data;
`endif
                    end
                    ST_DAT_LO: begin
                        r_wdata <= pl_pack(r_hi, rx_data);
                        r_we    <= 1'b1;
                        r_rem   <= r_rem - 16'd1;
`ifdef PROGLOADER_CHKSUM_EN
                        r_chk   <= r_chk ^ rx_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we       = r_we;
    assign mem_data     = r_wdata;
    assign mem_waddr    = r_words;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_progloader.sv
// tb_progloader: directed self-checking bench for progloader.
module tb_progloader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] mem_waddr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [15:0] wq_addr[$];
    logic [15:0] wq_data[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    progloader #(.DEPTH(1024)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_waddr(mem_waddr), .mem_data(mem_data),
        .mem_we(mem_we), .cpu_rst(cpu_rst), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    // Write log, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            wq_addr.push_back(mem_waddr);
            wq_data.push_back(mem_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        tick(); tick();
        rst = 1'b0;
        wq_addr.delete(); wq_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap, input string tag);
        bit acc;
        acc = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data = b; rx_valid = 1'b1;
        for (int i = 0; i < 16 && !acc; i++) begin
            acc = rx_ready;
            tick();
        end
        rx_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL %s accept_timeout byte=%02h rx_ready=%0b required=1", tag, b, rx_ready);
        end
    endtask

    task automatic send_q(input int unsigned max_gap, input string tag);
        foreach (tx_q[i]) send_byte(tx_q[i], (max_gap == 0) ? 0 : $urandom_range(max_gap, 0), tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL %s rx_ready got=%0b exp=1", tag, rx_ready); end
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL %s cpu_rst got=%0b exp=1", tag, cpu_rst); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL %s mem_we got=%0b exp=0", tag, mem_we); end
        checks++; if (mem_waddr !== 16'h0000) begin failures++; $display("FAIL %s mem_waddr got=%04h exp=0000", tag, mem_waddr); end
        checks++; if (mem_data !== 16'h0000) begin failures++; $display("FAIL %s mem_data got=%04h exp=0000", tag, mem_data); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s done got=%0b exp=0", tag, done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL %s error got=%0b exp=0", tag, error); end
        checks++; if (words_loaded !== 16'd0) begin failures++; $display("FAIL %s words_loaded got=%0d exp=0", tag, words_loaded); end
    endtask

    task automatic load_basic_stream();
        tx_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
`ifdef PROGLOADER_CHKSUM_EN
        tx_q.push_back(8'h41);
`endif
    endtask

    task automatic check_basic_writes(input string tag);
        logic [15:0] ea[3];
        logic [15:0] ed[3];
        ea = '{16'd0, 16'd1, 16'd2};
        ed = '{16'h1234, 16'hABCD, 16'h0001};
        checks++;
        if (wq_addr.size() != 3) begin
            failures++; $display("FAIL %s write_count got=%0d exp=3", tag, wq_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i]) begin
                    failures++;
                    $display("FAIL %s write%0d got=%04h@%04h exp=%04h@%04h", tag, i, wq_data[i], wq_addr[i], ed[i], ea[i]);
                end
            end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s done got=%0b exp=1", tag, done); end
        checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL %s cpu_rst got=%0b exp=0", tag, cpu_rst); end
        checks++; if (words_loaded !== 16'd3) begin failures++; $display("FAIL %s words_loaded got=%0d exp=3", tag, words_loaded); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        load_basic_stream();
        send_q(0, "basic");
        // cycle after the last accepted byte: FLUSH
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL basic flush_rx_ready got=%0b exp=0", rx_ready); end
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL basic flush_cpu_rst got=%0b exp=1", cpu_rst); end
`ifndef PROGLOADER_CHKSUM_EN
        checks++;
        if (mem_we !== 1'b1 || mem_waddr !== 16'd2 || mem_data !== 16'h0001) begin
            failures++;
            $display("FAIL basic final_write we=%0b addr=%04h data=%04h exp we=1 addr=0002 data=0001", mem_we, mem_waddr, mem_data);
        end
`endif
        tick();
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL basic we_pulse_len got=%0b exp=0", mem_we); end
        check_basic_writes("basic");
        // RUN ignores further bytes
        rx_data = 8'hAA; rx_valid = 1'b1;
        repeat (3) tick();
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL basic run_absorb rx_ready=%0b done=%0b exp 0/1", rx_ready, done); end
        checks++; if (wq_addr.size() != 3) begin failures++; $display("FAIL basic run_no_write got=%0d exp=3", wq_addr.size()); end
    endtask

    task automatic test_gaps();
        do_reset();
        load_basic_stream();
        send_q(3, "gaps");
        tick(); tick();
        check_basic_writes("gaps");
    endtask

    task automatic test_zero();
        do_reset();
        tx_q = '{8'h00, 8'h00};
`ifdef PROGLOADER_CHKSUM_EN
        tx_q.push_back(8'h00);
`endif
        send_q(0, "zero");
        tick();
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin failures++; $display("FAIL zero run done=%0b cpu_rst=%0b exp 1/0", done, cpu_rst); end
        checks++; if (wq_addr.size() != 0 || words_loaded !== 16'd0) begin failures++; $display("FAIL zero writes got=%0d words=%0d exp=0/0", wq_addr.size(), words_loaded); end
    endtask

    task automatic test_overflow();
        // N == DEPTH is legal
        do_reset();
        tx_q = '{8'h04, 8'h00};
        send_q(0, "depth");
        checks++; if (error !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL depth_ok error=%0b rx_ready=%0b exp 0/1", error, rx_ready); end
        // N == DEPTH+1 is rejected
        do_reset();
        tx_q = '{8'h04, 8'h01};
        send_q(0, "ovf");
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL ovf error got=%0b exp=1", error); end
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL ovf rx_ready got=%0b exp=0", rx_ready); end
        checks++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ovf cpu_rst=%0b done=%0b exp 1/0", cpu_rst, done); end
        rx_data = 8'h55; rx_valid = 1'b1;
        repeat (4) tick();
        rx_valid = 1'b0;
        checks++; if (error !== 1'b1 || wq_addr.size() != 0) begin failures++; $display("FAIL ovf sticky error=%0b writes=%0d exp 1/0", error, wq_addr.size()); end
    endtask

    task automatic test_midreset();
        do_reset();
        tx_q = '{8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22};
        send_q(0, "midrst");
        checks++; if (words_loaded !== 16'd1) begin failures++; $display("FAIL midrst words_before got=%0d exp=1", words_loaded); end
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        wq_addr.delete(); wq_data.delete();
        tx_q = '{8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef PROGLOADER_CHKSUM_EN
        tx_q.push_back(8'h51);
`endif
        send_q(0, "midrst");
        tick(); tick();
        checks++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 16'd0 || wq_data[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL midrst reload writes=%0d first=%04h@%04h exp=1 BEEF@0000", wq_addr.size(),
                     (wq_data.size() > 0) ? wq_data[0] : 16'hxxxx, (wq_addr.size() > 0) ? wq_addr[0] : 16'hxxxx);
        end
        checks++; if (done !== 1'b1 || words_loaded !== 16'd1) begin failures++; $display("FAIL midrst run done=%0b words=%0d exp 1/1", done, words_loaded); end
    endtask

`ifdef PROGLOADER_CHKSUM_EN
    task automatic test_chksum();
        do_reset();
        tx_q = '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'hFF};
        send_q(0, "chk_ok");
        tick();
        checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL chk_ok done=%0b error=%0b exp 1/0", done, error); end
        do_reset();
        tx_q = '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'h00};
        send_q(0, "chk_bad");
        tick();
        checks++; if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL chk_bad error=%0b cpu_rst=%0b done=%0b exp 1/1/0", error, cpu_rst, done); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_zero();
        test_overflow();
        test_midreset();
`ifdef PROGLOADER_CHKSUM_EN
        test_chksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
